rr_bus_arbiter: RTL and testbench

Four-master round-robin bus arbiter with bus locking and bounded tenure. It replaces the two-master fixed-park arbiter in front of the shared factorial-machine bus. Ownership is decided by rotating priority. A one-cycle handover gap with no grant separates owners. A hold counter forces a handover when an unlocked owner has held the bus for MAX_HOLD cycles while others wait.

---
 rtl/bus_pkg.sv | 17 +
 rtl/rr_pick.sv | 29 ++
 rtl/rr_bus_arbiter.sv | 80 ++++++++
 tb/tb_rr_bus_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the factorial-machine bus: master count, id width,
// arbiter state encoding and the one-hot grant helper.
package bus_pkg;

  localparam int NMASTERS = 4;
  localparam int ID_W     = 2;

  typedef enum logic {
    OWN = 1'b0,
    GAP = 1'b1
  } arb_state_t;

  function automatic logic [NMASTERS-1:0] onehot(input logic [ID_W-1:0] id);
    return NMASTERS'(1) << id;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: finds the first requester after the current
// owner, searching owner+1, owner+2, owner+3 (mod 4); the owner is never picked.
module rr_pick
  import bus_pkg::*;
(
  input  logic [NMASTERS-1:0] req,
  input  logic [ID_W-1:0]     owner,
  output logic [ID_W-1:0]     nxt,
  output logic                any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
    nxt = '0;
    any = 1'b0;
    idx = '0;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int k = NMASTERS - 1; k >= 1; k--) begin
      idx = owner + ID_W'(k);
      if (req[idx]) begin
        nxt = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Four-master round-robin bus arbiter with per-owner lock, a one-cycle
// no-grant handover gap, and a hold counter that bounds unlocked tenure.
module rr_bus_arbiter
  import bus_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NMASTERS-1:0] req,
  input  logic [NMASTERS-1:0] lock,
  output logic [NMASTERS-1:0] grant,
  output logic [ID_W-1:0]     grant_id,
  output logic                gap,
  output logic                preempt
);

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  arb_state_t      state;
  logic [ID_W-1:0] owner;
  logic [7:0]      hold_cnt;
  logic [ID_W-1:0] nxt;
  logic            any;
  logic            owner_req;
  logic            expired;

  rr_pick u_pick (
    .req   (req),
    .owner (owner),
    .nxt   (nxt),
    .any   (any)
  );

  assign owner_req = req[owner];
  assign expired   = !lock[owner] && (hold_cnt >= HOLD_LIMIT);

  // NOTE: all state here is updated with non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= OWN;
      owner    <= '0;
      hold_cnt <= '0;
      grant    <= onehot('0);
      grant_id <= '0;
      gap      <= 1'b0;
      preempt  <= 1'b0;
    end else begin
      case (state)
        OWN: begin
          preempt <= 1'b0;
          if (any && owner_req && hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
          // A parked owner (no other requester) keeps the grant indefinitely.
          if (any && (!owner_req || expired)) begin
            state    <= GAP;
            owner    <= nxt;
            grant_id <= nxt;
            grant    <= '0;
            gap      <= 1'b1;
            preempt  <= owner_req;
          end
        end
        GAP: begin
          // Requests are deliberately not re-evaluated; the incoming owner is committed.
          state    <= OWN;
          grant    <= onehot(owner);
          gap      <= 1'b0;
          preempt  <= 1'b0;
          hold_cnt <= '0;
        end
        default: begin
          state <= OWN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench for rr_bus_arbiter: vector table, hand-written corner
// sequences, and randomized traffic against a cycle-level reference model.
module tb_rr_bus_arbiter;
  import bus_pkg::*;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] lock;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       gap;
  logic       preempt;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rr_bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .lock     (lock),
    .grant    (grant),
    .grant_id (grant_id),
    .gap      (gap),
    .preempt  (preempt)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] grant;
    logic [1:0] id;
    logic       gap;
    logic       pre;
  } vec_t;

  vec_t vecs[20];

  // Reference model state: owner index, gap flag, contended-cycle count, preempt.
  int m_owner;
  bit m_gap;
  int m_hold;
  bit m_pre;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Packed as {grant, grant_id, gap, preempt}.
  task automatic check_outs(input string name, input logic [3:0] g, input logic [1:0] id,
                            input logic gp, input logic pr);
    check(name, {24'd0, grant, grant_id, gap, preempt}, {24'd0, g, id, gp, pr});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_gap   = 1'b0;
    m_hold  = 0;
    m_pre   = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] l);
    int  nx;
    bit  handover;
    if (m_gap) begin
      m_gap  = 1'b0;
      m_hold = 0;
      m_pre  = 1'b0;
      return;
    end
    m_pre = 1'b0;
    nx = -1;
    for (int k = 1; k < 4; k++) begin
      int cand;
      cand = (m_owner + k) % 4;
      if (r[cand] && nx < 0) nx = cand;
    end
    if (nx < 0) return;
    handover = !r[m_owner] || (!l[m_owner] && m_hold >= MAX_HOLD - 1);
    if (r[m_owner]) m_hold = (m_hold < 255) ? m_hold + 1 : 255;
    if (handover) begin
      m_pre   = r[m_owner];
      m_owner = nx;
      m_gap   = 1'b1;
    end
  endtask

  function automatic logic [3:0] model_grant();
    return m_gap ? 4'b0000 : 4'(1 << m_owner);
  endfunction

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         seen;
    logic [3:0] r;
    logic [3:0] l;

    reset = 1'b1;
    req   = '0;
    lock  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset_state", 4'b0001, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step();
      check_outs($sformatf("idle_%0d", i), 4'b0001, 2'd0, 1'b0, 1'b0);
    end

    // Voluntary handover, hold expiry at MAX_HOLD=4, then a three-way release chain.
    vecs[0]  = '{4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{4'b0100, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0};
    vecs[2]  = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b0};
    vecs[3]  = '{4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b0};
    vecs[4]  = '{4'b0010, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0};
    vecs[5]  = '{4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0};
    vecs[6]  = '{4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0};
    vecs[7]  = '{4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0};
    vecs[8]  = '{4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0};
    vecs[9]  = '{4'b1010, 4'b0000, 4'b0000, 2'd3, 1'b1, 1'b1};
    vecs[10] = '{4'b1010, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b0};
    vecs[11] = '{4'b1010, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b0};
    vecs[12] = '{4'b0100, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0};
    vecs[13] = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b0};
    vecs[14] = '{4'b1011, 4'b0000, 4'b0000, 2'd3, 1'b1, 1'b0};
    vecs[15] = '{4'b1011, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b0};
    vecs[16] = '{4'b0011, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0};
    vecs[17] = '{4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b0};
    vecs[18] = '{4'b0010, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0};
    vecs[19] = '{4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0};
    for (int i = 0; i < 20; i++) begin
      req  = vecs[i].req;
      lock = vecs[i].lock;
      step();
      check_outs($sformatf("vec_%0d", i), vecs[i].grant, vecs[i].id, vecs[i].gap, vecs[i].pre);
    end

    // Lock holds the bus far beyond MAX_HOLD; releasing it hands over promptly with preempt.
    req  = '0;
    lock = '0;
    pulse_reset();
    req = 4'b0010;
    step();
    step();
    check_outs("lock_setup", 4'b0010, 2'd1, 1'b0, 1'b0);
    req  = 4'b1010;
    lock = 4'b0010;
    for (int i = 0; i < 50; i++) begin
      step();
      check_outs($sformatf("locked_%0d", i), 4'b0010, 2'd1, 1'b0, 1'b0);
    end
    lock = 4'b0000;
    seen = 1'b0;
    for (int i = 0; i < MAX_HOLD + 1 && !seen; i++) begin
      step();
      if (gap) begin
        seen = 1'b1;
        check_outs("unlock_gap", 4'b0000, 2'd3, 1'b1, 1'b1);
      end
    end
    check("unlock_within_bound", {31'd0, seen}, 32'd1);
    step();
    check_outs("unlock_new_owner", 4'b1000, 2'd3, 1'b0, 1'b0);

    // Reset lands during the gap toward master 3.
    req = '0;
    pulse_reset();
    req = 4'b1000;
    step();
    check_outs("gap_toward_3", 4'b0000, 2'd3, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    req   = 4'b0000;
    #1;
    check_outs("reset_in_gap", 4'b0001, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_outs($sformatf("after_reset_%0d", i), 4'b0001, 2'd0, 1'b0, 1'b0);
    end
    req = 4'b1000;
    step();
    check_outs("rewin_gap", 4'b0000, 2'd3, 1'b1, 1'b0);
    step();
    check_outs("rewin_grant", 4'b1000, 2'd3, 1'b0, 1'b0);

    // Randomized traffic against the reference model, with occasional async resets.
    req  = '0;
    lock = '0;
    pulse_reset();
    model_reset();
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0) r = 4'($urandom_range(0, 15));
      l = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      req  = r;
      lock = l;
      step();
      model_step(r, l);
      check_outs($sformatf("rand_%0d", i), model_grant(), 2'(m_owner), m_gap, m_pre);
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        #1;
        check_outs($sformatf("rand_reset_%0d", i), 4'b0001, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        model_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
